multiplier: RTL and testbench
=============================

// Module: multiplier
// PURPOSE
//  Sequential unsigned shift-add multiplier. Inverse operation of the divider
//  unit, with the same start/busy/valid handshake so both can share one
//  arithmetic-unit wrapper.
//  Product width equals the operand width; high-half loss is flagged on ovf.
//  Split into a datapath and a controller, matching the divider's structure.
// PARAMETERS
//  WIDTH  10  operand/result width in bits; accumulator is 2*WIDTH bits
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      asynchronous reset, active-high
//  sclr    in   1      synchronous clear, active-high; same effect as rst
//  start   in   1      request; sampled only in IDLE
//  a_in    in   WIDTH  multiplicand, captured on the accepted start edge
//  b_in    in   WIDTH  multiplier, captured on the accepted start edge
//  busy    out  1      high while in CALC
//  valid   out  1      one-cycle pulse in DONE; p_out/ovf are final
//  ovf     out  1      acc[2W-1:W] != 0; held with p_out
//  p_out   out  WIDTH  acc[W-1:0]; held until the next DONE
// BEHAVIOUR
//  Reset (rst or sclr)
//   - State is IDLE; busy=0, valid=0, ovf=0, p_out=0.
//   - Internal A, B, acc and cnt are cleared.
//   - rst acts immediately; sclr acts on the next edge.
//   - A reset mid-operation aborts it. No valid pulse is produced.
//  FSM states: IDLE, CALC, DONE (2-bit encoding)
//   IDLE & start:
//    - A <= a_in (zero-extended to 2W); B <= b_in; acc <= 0; cnt <= 0.
//    - If a_in==0 or b_in==0, go to DONE. Otherwise go to CALC.
//   CALC, one step per cycle:
//    - If B[0]: acc <= acc + A.
//    - A <= A<<1; B <= B>>1; cnt <= cnt+1.
//    - Go to DONE when (B>>1)==0 or cnt==WIDTH-1. Otherwise stay in CALC.
//   DONE:
//    - valid=1 for exactly one cycle.
//    - p_out and ovf are registered from the final acc.
//    - Always returns to IDLE.
//  Latency
//   - Let k = (index of MSB of b_in) + 1, so 1..WIDTH.
//   - k CALC cycles; valid is in cycle k+1 after the start edge.
//   - A zero operand gives valid in cycle 1 after start, with p_out=0 and ovf=0.
//  Handshake
//   - start is ignored in CALC and DONE. No queuing.
//   - Operands may change freely after the start edge.
//   - Back-to-back: start in the cycle after DONE (IDLE) is accepted.
//  Arithmetic
//   - The add is 2W bits wide with no carry loss. The max product (2^W-1)^2 fits.
//  Priority: rst > sclr > start.
// STRUCTURE
//  - Shared package/header mul_defs:
//     state encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2; default WIDTH.
//  - Sub-modules:
//     mult_datapath (A/B/acc/cnt registers; status Bnz, cnt_last, opz).
//     mult_controller (FSM; ldA, ldB, clrAcc, add, sh, ldOut).
//  - The top level only wires the two sub-modules together.
// TESTING
//  1. a=3,b=5: busy for 3 cycles; valid in cycle 4 with p_out=15, ovf=0.
//  2. a=0,b=700, then a=700,b=0: valid in cycle 1 each time; p_out=0, ovf=0;
//     busy never high.
//  3. a=1023,b=1023: 10 CALC cycles; p_out=10'h001, ovf=1.
//     a=32,b=32: p_out=0, ovf=1. a=31,b=33: p_out=1023, ovf=0.
//  4. a=6,b=7, then start pulsed again with a=2,b=2 while busy:
//     the second start is ignored; valid once, p_out=42.
//  5. Assert rst in the 2nd CALC cycle of a=100,b=9:
//     busy/valid/p_out/ovf go to 0 immediately and no valid follows.
//     Repeat the abort using sclr: same result one edge later.
//  6. Back-to-back: start again in the IDLE cycle after DONE (2*3, then 4*4):
//     valid twice; p_out=6 is held until 16 appears.

Source files
------------

// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared state encoding and default operand width for the multiplier.
package multiplier_pkg;
    localparam int DEFAULT_WIDTH = 10;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/multiplier_if.sv
// multiplier_if: start/busy/valid handshake bundle for the multiplier.
// Ports: start, a_in, b_in driven by the master; busy, valid, ovf, p_out driven by the slave.
interface multiplier_if #(parameter int WIDTH = multiplier_pkg::DEFAULT_WIDTH);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             valid;
    logic             ovf;
    logic [WIDTH-1:0] p_out;
    modport master (output start, a_in, b_in, input busy, valid, ovf, p_out);
    modport slave  (input start, a_in, b_in, output busy, valid, ovf, p_out);
endinterface

// File: rtl/multiplier_controller.sv
// multiplier_controller: IDLE/CALC/DONE sequencer driving the datapath.
// Ports: clk, rst (async), sclr (sync), start; status b_lsb, b_nz, cnt_last, opz;
//        control ld_a, ld_b, clr_acc, add, sh, ld_out; handshake busy, valid.
module multiplier_controller
    import multiplier_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sclr,
    input  logic start,
    input  logic b_lsb,
    input  logic b_nz,
    input  logic cnt_last,
    input  logic opz,
    output logic ld_a,
    output logic ld_b,
    output logic clr_acc,
    output logic add,
    output logic sh,
    output logic ld_out,
    output logic busy,
    output logic valid
);
    state_t state, nxt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       state <= IDLE;
        else if (sclr) state <= IDLE;
        else           state <= nxt;
    end
    always_comb begin
        nxt     = state;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        clr_acc = 1'b0;
        add     = 1'b0;
        sh      = 1'b0;
        ld_out  = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                ld_a    = 1'b1;
                ld_b    = 1'b1;
                clr_acc = 1'b1;
                // A zero operand skips CALC; the cleared acc becomes the result.
                ld_out  = opz;
                nxt     = opz ? DONE : CALC;
            end
            CALC: begin
                sh     = 1'b1;
                add    = b_lsb;
                ld_out = !b_nz || cnt_last;
                nxt    = (!b_nz || cnt_last) ? DONE : CALC;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    assign busy  = state == CALC;
    assign valid = state == DONE;
endmodule

// File: rtl/multiplier_datapath.sv
// multiplier_datapath: shift-add registers (A, B, acc, cnt) plus the held result.
// Ports: clk, rst (async), sclr (sync); control ld_a, ld_b, clr_acc, add, sh, ld_out;
//        operands a_in, b_in; status b_lsb, b_nz, cnt_last, opz; results p_out, ovf.
module multiplier_datapath #(
    parameter int WIDTH = multiplier_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclr,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             clr_acc,
    input  logic             add,
    input  logic             sh,
    input  logic             ld_out,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             b_lsb,
    output logic             b_nz,
    output logic             cnt_last,
    output logic             opz,
    output logic [WIDTH-1:0] p_out,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [2*WIDTH-1:0] a_reg, acc, acc_d;
    logic [WIDTH-1:0]   b_reg;
    logic [CW-1:0]      cnt;
    // acc_d is the value acc takes this edge; the result is captured from it so
    // p_out/ovf are already final in the DONE cycle.
    assign acc_d    = clr_acc ? '0 : add ? acc + a_reg : acc;
    assign b_lsb    = b_reg[0];
    assign b_nz     = |b_reg[WIDTH-1:1];
    assign cnt_last = cnt == CW'(WIDTH - 1);
    assign opz      = (a_in == '0) || (b_in == '0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst || sclr) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            p_out <= '0;
            ovf   <= 1'b0;
        end else begin
            a_reg <= ld_a ? {{WIDTH{1'b0}}, a_in} : sh ? a_reg << 1 : a_reg;
            b_reg <= ld_b ? b_in : sh ? b_reg >> 1 : b_reg;
            cnt   <= ld_b ? '0 : sh ? cnt + CW'(1) : cnt;
            acc   <= acc_d;
            if (ld_out) begin
                p_out <= acc_d[WIDTH-1:0];
                ovf   <= |acc_d[2*WIDTH-1:WIDTH];
            end
        end
    end
endmodule

// File: rtl/multiplier.sv
// multiplier: sequential unsigned shift-add multiplier, WIDTH x WIDTH -> WIDTH with ovf.
// Ports: clk, rst (async, active-high), sclr (sync clear), bus (multiplier_if slave).
module multiplier
    import multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclr,
    multiplier_if.slave bus
);
    logic ld_a, ld_b, clr_acc, add, sh, ld_out;
    logic b_lsb, b_nz, cnt_last, opz;
    multiplier_controller u_ctrl (
        .clk(clk), .rst(rst), .sclr(sclr), .start(bus.start),
        .b_lsb(b_lsb), .b_nz(b_nz), .cnt_last(cnt_last), .opz(opz),
        .ld_a(ld_a), .ld_b(ld_b), .clr_acc(clr_acc), .add(add), .sh(sh), .ld_out(ld_out),
        .busy(bus.busy), .valid(bus.valid)
    );
    multiplier_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk(clk), .rst(rst), .sclr(sclr),
        .ld_a(ld_a), .ld_b(ld_b), .clr_acc(clr_acc), .add(add), .sh(sh), .ld_out(ld_out),
        .a_in(bus.a_in), .b_in(bus.b_in),
        .b_lsb(b_lsb), .b_nz(b_nz), .cnt_last(cnt_last), .opz(opz),
        .p_out(bus.p_out), .ovf(bus.ovf)
    );
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: directed self-checking bench for the multiplier.
module tb_multiplier;
    localparam int W = 10;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclr = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    multiplier_if #(.WIDTH(W)) bus ();
    multiplier #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .sclr(sclr), .bus(bus));

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a_in  = ~a;
        bus.b_in  = ~b;
    endtask

    task automatic collect(output int vc, output int bc, output logic [W-1:0] p, output logic o);
        vc = 0;
        bc = 0;
        p  = '0;
        o  = 1'b0;
        for (int c = 1; c <= 40 && vc == 0; c++) begin
            if (bus.busy) bc++;
            if (bus.valid) begin
                vc = c;
                p  = bus.p_out;
                o  = bus.ovf;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ep,
                            input logic eo, input int k, input string nm);
        int vc, bc;
        logic [W-1:0] p;
        logic o;
        launch(a, b);
        collect(vc, bc, p, o);
        n_cmp++;
        if (vc !== k + 1) begin n_bad++; $display("FAIL %s valid_cycle: got %0d expected %0d", nm, vc, k + 1); end
        n_cmp++;
        if (bc !== k) begin n_bad++; $display("FAIL %s busy_cycles: got %0d expected %0d", nm, bc, k); end
        n_cmp++;
        if (p !== ep) begin n_bad++; $display("FAIL %s p_out: got %0d expected %0d", nm, p, ep); end
        n_cmp++;
        if (o !== eo) begin n_bad++; $display("FAIL %s ovf: got %0b expected %0b", nm, o, eo); end
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL %s valid_width: got %0b expected 0", nm, bus.valid); end
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.valid, bus.ovf, bus.p_out} !== '0) begin
            n_bad++; $display("FAIL reset_async: got %h expected 0", {bus.busy, bus.valid, bus.ovf, bus.p_out});
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.busy, bus.valid, bus.ovf, bus.p_out} !== '0) begin
            n_bad++; $display("FAIL reset_held: got %h expected 0", {bus.busy, bus.valid, bus.ovf, bus.p_out});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        test_vec(10'd3, 10'd5, 10'd15, 1'b0, 3, "3x5");
    endtask

    task automatic test_zero();
        test_vec(10'd0, 10'd700, 10'd0, 1'b0, 0, "0x700");
        test_vec(10'd700, 10'd0, 10'd0, 1'b0, 0, "700x0");
    endtask

    task automatic test_overflow();
        test_vec(10'd1023, 10'd1023, 10'h001, 1'b1, 10, "1023x1023");
        test_vec(10'd32, 10'd32, 10'd0, 1'b1, 6, "32x32");
        test_vec(10'd31, 10'd33, 10'd1023, 1'b0, 6, "31x33");
    endtask

    task automatic test_ignore_busy();
        int nv = 0;
        int vc = 0;
        logic [W-1:0] p = '0;
        launch(10'd6, 10'd7);
        bus.start = 1'b1;
        bus.a_in  = 10'd2;
        bus.b_in  = 10'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 2; c <= 14; c++) begin
            if (bus.valid) begin
                nv++;
                if (vc == 0) begin vc = c; p = bus.p_out; end
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (nv !== 1) begin n_bad++; $display("FAIL ignore_busy valid_count: got %0d expected 1", nv); end
        n_cmp++;
        if (vc !== 4) begin n_bad++; $display("FAIL ignore_busy valid_cycle: got %0d expected 4", vc); end
        n_cmp++;
        if (p !== 10'd42) begin n_bad++; $display("FAIL ignore_busy p_out: got %0d expected 42", p); end
    endtask

    task automatic test_abort_rst();
        int seen = 0;
        launch(10'd100, 10'd9);
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL abort_rst pre_busy: got %0b expected 1", bus.busy); end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.valid, bus.ovf, bus.p_out} !== '0) begin
            n_bad++; $display("FAIL abort_rst outputs: got %h expected 0", {bus.busy, bus.valid, bus.ovf, bus.p_out});
        end
        #2;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.valid || bus.busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL abort_rst after: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_abort_sclr();
        int seen = 0;
        test_vec(10'd3, 10'd5, 10'd15, 1'b0, 3, "pre_sclr_3x5");
        launch(10'd100, 10'd9);
        @(posedge clk);
        #1;
        sclr = 1'b1;
        #1;
        n_cmp++;
        if ({bus.busy, bus.p_out} !== {1'b1, 10'd15}) begin
            n_bad++; $display("FAIL abort_sclr before_edge: got %h expected %h", {bus.busy, bus.p_out}, {1'b1, 10'd15});
        end
        @(posedge clk);
        #1;
        sclr = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.valid, bus.ovf, bus.p_out} !== '0) begin
            n_bad++; $display("FAIL abort_sclr outputs: got %h expected 0", {bus.busy, bus.valid, bus.ovf, bus.p_out});
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.valid || bus.busy) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL abort_sclr after: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        int vc, bc;
        int hv = 0;
        int vc2 = 0;
        logic [W-1:0] p;
        logic o;
        launch(10'd2, 10'd3);
        collect(vc, bc, p, o);
        n_cmp++;
        if ({vc, p} !== {32'd3, 10'd6}) begin n_bad++; $display("FAIL b2b first: got cycle %0d p %0d expected cycle 3 p 6", vc, p); end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.valid, bus.p_out} !== {1'b0, 10'd6}) begin
            n_bad++; $display("FAIL b2b idle_hold: got valid %0b p %0d expected valid 0 p 6", bus.valid, bus.p_out);
        end
        bus.start = 1'b1;
        bus.a_in  = 10'd4;
        bus.b_in  = 10'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c <= 20 && vc2 == 0; c++) begin
            if (bus.valid) begin
                vc2 = c;
                p   = bus.p_out;
            end else begin
                if (bus.p_out !== 10'd6) hv++;
                @(posedge clk);
                #1;
            end
        end
        n_cmp++;
        if (hv !== 0) begin n_bad++; $display("FAIL b2b hold: got %0d cycles without p_out=6 expected 0", hv); end
        n_cmp++;
        if (vc2 !== 4) begin n_bad++; $display("FAIL b2b second_cycle: got %0d expected 4", vc2); end
        n_cmp++;
        if (p !== 10'd16) begin n_bad++; $display("FAIL b2b second_p: got %0d expected 16", p); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        test_reset();
        test_basic();
        test_zero();
        test_overflow();
        test_ignore_busy();
        test_abort_rst();
        test_abort_sclr();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
